aes_core_arbiter: RTL

Shares one iterative AES core between two requesters: requester 0 is the RISC-V MMIO port and requester 1 is the secondary/DMA port. Requests are granted round-robin. For each granted request the block latches key, data and mode, pulses the core start, waits for done or a timeout, then returns the result to the granted requester. It sits between the processor-side bus adapters and the AES core inside `system`.

---
 rtl/aes_core_arbiter_if.sv | 41 ++++
 rtl/aes_core_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter_if.sv
// Bundles the two requester ports, the shared response path and the AES core
// operand/status signals. The arbiter takes the slave side; the environment takes the master side.
interface aes_core_arbiter_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 8
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_decrypt;
  logic [DATA_W-1:0] req0_key;
  logic [DATA_W-1:0] req1_key;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              aes_start;
  logic [DATA_W-1:0] aes_key;
  logic [DATA_W-1:0] aes_din;
  logic              aes_decrypt;
  logic              aes_done;
  logic [DATA_W-1:0] aes_dout;
  logic              busy;
  logic              grant_id;
  logic [CNT_W-1:0]  timeout_cnt;

  modport slave (
    input  req_valid, req_decrypt, req0_key, req1_key, req0_data, req1_data,
           resp_ready, aes_done, aes_dout,
    output req_ready, resp_valid, resp_data, resp_err, aes_start, aes_key,
           aes_din, aes_decrypt, busy, grant_id, timeout_cnt
  );

  modport master (
    output req_valid, req_decrypt, req0_key, req1_key, req0_data, req1_data,
           resp_ready, aes_done, aes_dout,
    input  req_ready, resp_valid, resp_data, resp_err, aes_start, aes_key,
           aes_din, aes_decrypt, busy, grant_id, timeout_cnt
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one iterative AES core between the MMIO requester (0)
// and the DMA requester (1), with a per-operation timeout and saturating timeout counter.
module aes_core_arbiter #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic              clk,
  input logic              reset,
  aes_core_arbiter_if.slave bus
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  // IDLE: arbitrate | ISSUE: start pulse | WAIT: done or timeout | RESP: hold result
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              dec_q, dec_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;

  logic              win;
  logic [1:0]        req_ready_c;
  logic [1:0]        resp_valid_c;
  logic              start_c;

  // a tie goes to whoever was not served last
  always_comb begin
    case (bus.req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_grant_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dec_d        = dec_q;
    key_d        = key_q;
    din_d        = din_q;
    timer_d      = timer_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    tcnt_d       = tcnt_q;
    req_ready_c  = 2'b00;
    resp_valid_c = 2'b00;
    start_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|bus.req_valid) && !reset) begin
          req_ready_c[win] = 1'b1;
          grant_d          = win;
          key_d            = win ? bus.req1_key  : bus.req0_key;
          din_d            = win ? bus.req1_data : bus.req0_data;
          dec_d            = bus.req_decrypt[win];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        start_c = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.aes_done) begin
          rdata_d = bus.aes_dout;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_W'(1);
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_c[grant_q] = 1'b1;
        if (bus.resp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      dec_q        <= 1'b0;
      key_q        <= '0;
      din_q        <= '0;
      timer_q      <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      dec_q        <= dec_d;
      key_q        <= key_d;
      din_q        <= din_d;
      timer_q      <= timer_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
      tcnt_q       <= tcnt_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.resp_valid  = resp_valid_c;
  assign bus.aes_start   = start_c;
  assign bus.aes_key     = (state_q != IDLE) ? key_q : '0;
  assign bus.aes_din     = (state_q != IDLE) ? din_q : '0;
  assign bus.aes_decrypt = (state_q != IDLE) ? dec_q : 1'b0;
  assign bus.resp_data   = rdata_q;
  assign bus.resp_err    = rerr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.timeout_cnt = tcnt_q;

endmodule
